// File: rtl/modulo_pc_if.sv
// ---------------------------------------------------------------------------
// modulo_pc_if
// Bundles the command inputs and status outputs of the program-counter stage.
//   master : the next-address/decode side; drives novo_endereco, habilita_pc,
//            chamada, retorno, halt, retomar; observes the PC status.
//   slave  : the program-counter stage itself; consumes the commands and
//            drives pc_atual, busca_valida, parado, erro_pilha, profundidade.
// ---------------------------------------------------------------------------
interface modulo_pc_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int PILHA_PROF = 8
);
  localparam int PROF_W = $clog2(PILHA_PROF) + 1;

  logic [ADDR_WIDTH-1:0] novo_endereco;
  logic                  habilita_pc;
  logic                  chamada;
  logic                  retorno;
  logic                  halt;
  logic                  retomar;

  logic [ADDR_WIDTH-1:0] pc_atual;
  logic                  busca_valida;
  logic                  parado;
  logic                  erro_pilha;
  logic [PROF_W-1:0]     profundidade;

  modport master (
    output novo_endereco, habilita_pc, chamada, retorno, halt, retomar,
    input  pc_atual, busca_valida, parado, erro_pilha, profundidade
  );

  modport slave (
    input  novo_endereco, habilita_pc, chamada, retorno, halt, retomar,
    output pc_atual, busca_valida, parado, erro_pilha, profundidade
  );
endinterface

// File: rtl/modulo_pc.sv
// ---------------------------------------------------------------------------
// modulo_pc
// Program-counter register stage with boot bubble, stall, halt/resume and a
// hardware return-address stack for call/return.
// Ports:
//   clock   : rising-edge system clock
//   reset_n : asynchronous active-low reset
//   bus     : modulo_pc_if.slave (commands in, PC and status out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module modulo_pc #(
  parameter int ADDR_WIDTH = 13,
  parameter int PILHA_PROF = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  modulo_pc_if.slave  bus
);
  localparam int PTR_W  = $clog2(PILHA_PROF);
  localparam int PROF_W = PTR_W + 1;
  localparam logic [PROF_W-1:0] PROF_MAX = PROF_W'(PILHA_PROF);
  localparam logic [PROF_W-1:0] PROF_UM  = PROF_W'(1);
  localparam logic [PTR_W-1:0]  PTR_UM   = PTR_W'(1);

  typedef enum logic [1:0] {
    INICIO  = 2'd0,
    EXECUTA = 2'd1,
    PARADO  = 2'd2,
    ERRO    = 2'd3
  } estado_t;

  // Wrapping address increment (the carry out of the top bit is dropped).
  function automatic logic [ADDR_WIDTH-1:0] incr_addr(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  estado_t               estado_r;
  estado_t               estado_next_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_next_s;
  logic [PROF_W-1:0]     prof_r;
  logic [PROF_W-1:0]     prof_next_s;
  logic                  busca_valida_r;
  logic                  parado_r;
  logic                  erro_pilha_r;
  logic                  erro_set_s;
  logic                  push_s;
  logic [PTR_W-1:0]      push_idx_s;
  logic [PTR_W-1:0]      topo_idx_s;
  logic [ADDR_WIDTH-1:0] pilha_r [PILHA_PROF];

  // Stack slot addressing: depth is a power of two, so the low bits of the
  // occupancy count index the next free slot and (count-1) the top entry.
  always_comb begin
    push_idx_s = prof_r[PTR_W-1:0];
    topo_idx_s = prof_r[PTR_W-1:0] - PTR_UM;
  end

  // Next-state, next-PC and stack-command decode.
  always_comb begin
    estado_next_s = estado_r;
    pc_next_s     = pc_r;
    prof_next_s   = prof_r;
    erro_set_s    = 1'b0;
    push_s        = 1'b0;
    case (estado_r)
      INICIO: begin
        estado_next_s = EXECUTA;
      end
      EXECUTA: begin
        if (bus.habilita_pc) begin
          if (bus.halt) begin
            estado_next_s = PARADO;
          end else if (bus.retorno) begin
            // retorno outranks chamada when both are raised
            if (prof_r != {PROF_W{1'b0}}) begin
              pc_next_s   = pilha_r[topo_idx_s];
              prof_next_s = prof_r - PROF_UM;
            end else begin
              erro_set_s    = 1'b1;
              estado_next_s = ERRO;
            end
          end else if (bus.chamada) begin
            if (prof_r != PROF_MAX) begin
              push_s      = 1'b1;
              prof_next_s = prof_r + PROF_UM;
              pc_next_s   = bus.novo_endereco;
            end else begin
              erro_set_s    = 1'b1;
              estado_next_s = ERRO;
            end
          end else begin
            pc_next_s = bus.novo_endereco;
          end
        end else begin
          estado_next_s = EXECUTA;
        end
      end
      PARADO: begin
        if (bus.retomar) begin
          pc_next_s     = incr_addr(pc_r);
          estado_next_s = EXECUTA;
        end else begin
          estado_next_s = PARADO;
        end
      end
      ERRO: begin
        estado_next_s = ERRO;
      end
      default: begin
        // An illegal encoding is treated as a fault and locked out.
        erro_set_s    = 1'b1;
        estado_next_s = ERRO;
      end
    endcase
  end

  // State, PC, occupancy and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_r       <= INICIO;
      pc_r           <= {ADDR_WIDTH{1'b0}};
      prof_r         <= {PROF_W{1'b0}};
      busca_valida_r <= 1'b0;
      parado_r       <= 1'b0;
      erro_pilha_r   <= 1'b0;
    end else begin
      estado_r       <= estado_next_s;
      pc_r           <= pc_next_s;
      prof_r         <= prof_next_s;
      busca_valida_r <= (estado_next_s == EXECUTA);
      parado_r       <= (estado_next_s == PARADO);
      erro_pilha_r   <= erro_pilha_r | erro_set_s;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      pilha_r[push_idx_s] <= incr_addr(pc_r);
    end
  end

  assign bus.pc_atual     = pc_r;
  assign bus.busca_valida = busca_valida_r;
  assign bus.parado       = parado_r;
  assign bus.erro_pilha   = erro_pilha_r;
  assign bus.profundidade = prof_r;
endmodule

// File: doc/modulo_pc.md
Name: modulo_pc

Overview:
- Program-counter register stage that consumes the next-address value from the branch/next-address stage and holds the current fetch address.
- Feeds pc_atual back to that stage and to instruction memory.
- Adds a boot bubble, stall, halt/resume, and a hardware return-address stack for call/return instructions.
- Sits between the next-address selector and the instruction-memory address port.

Parameters:
- ADDR_WIDTH, 13, width of instruction addresses and of pc_atual.
- PILHA_PROF, 8, return-stack depth in entries. Power of two, at least 2.

Ports:
- clock, input, 1, system clock. Everything is rising-edge.
- reset_n, input, 1, asynchronous active-low reset.
- novo_endereco, input, ADDR_WIDTH, next address from the branch stage (branch target or pc+1).
- habilita_pc, input, 1, advance enable. 0 means stall and hold all state.
- chamada, input, 1, current instruction is a call: push the return address and jump to novo_endereco.
- retorno, input, 1, current instruction is a return: pop the stack into the PC.
- halt, input, 1, current instruction is a halt.
- retomar, input, 1, single-cycle pulse that leaves HALT.
- pc_atual, output, ADDR_WIDTH, current fetch address.
- busca_valida, output, 1, pc_atual is a valid fetch this cycle.
- parado, output, 1, block is in HALT.
- erro_pilha, output, 1, sticky stack overflow or underflow flag.
- profundidade, output, log2(PILHA_PROF)+1, current stack occupancy.

Behaviour:
- Reset is asynchronous on reset_n=0 and applies at any time, including mid-call or during HALT. On reset:
  - pc_atual=0, estado=INICIO, busca_valida=0, parado=0, erro_pilha=0, profundidade=0.
  - Stack contents need not be cleared.
- States: INICIO, EXECUTA, PARADO, ERRO.
- INICIO lasts exactly one cycle after reset release. PC holds at 0, busca_valida=0, then the block moves to EXECUTA. The first valid fetch is address 0 on the cycle after INICIO.
- EXECUTA: busca_valida=1.
  - habilita_pc=0: all state holds and all commands are ignored.
  - habilita_pc=1: commands are taken with priority halt > retorno > chamada > normal. Exactly one action is taken per cycle.
- halt: PC holds and the next state is PARADO.
- retorno:
  - profundidade>0: pc_atual <= top entry, profundidade decrements.
  - profundidade=0 (underflow): erro_pilha <= 1, next state ERRO, PC holds.
- chamada:
  - profundidade<PILHA_PROF: push (pc_atual+1) mod 2^ADDR_WIDTH, profundidade increments, pc_atual <= novo_endereco.
  - profundidade=PILHA_PROF (overflow): erro_pilha <= 1, next state ERRO, PC and stack unchanged.
- normal: pc_atual <= novo_endereco.
- chamada and retorno asserted in the same cycle: the retorno action is taken and chamada is ignored.
- PARADO: parado=1, busca_valida=0, PC and stack hold, and habilita_pc and all commands are ignored. When retomar=1, pc_atual <= (pc_atual+1) mod 2^ADDR_WIDTH and the next state is EXECUTA. retomar outside PARADO has no effect.
- ERRO: busca_valida=0, erro_pilha=1, everything holds until reset_n.
- All outputs are registered. There is no combinational path from inputs to outputs. Command-to-PC latency is 1 cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. For example, a call at pc_atual=0x1FFF pushes 0x0000.

Test Plan:
- Reset then release → pc_atual=0 and busca_valida=0 for 1 cycle, then busca_valida=1. With novo_endereco=1,2,3 on successive habilita_pc=1 cycles, pc_atual=1,2,3.
- At pc_atual=0x010, chamada=1 with novo_endereco=0x100 → pc_atual=0x100 and profundidade=1. Later retorno=1 → pc_atual=0x011 and profundidade=0.
- 8 nested chamadas → profundidade=8. A 9th chamada → erro_pilha=1, state ERRO, pc_atual unchanged, busca_valida=0 until reset.
- retorno with profundidade=0 → erro_pilha=1 and state ERRO. Separately, chamada and retorno together with profundidade=1 → pop only and profundidade=0.
- halt at pc_atual=0x020 → parado=1 and pc held at 0x020 for 5 cycles despite novo_endereco changing. retomar pulse → pc_atual=0x021 and parado=0.
- habilita_pc=0 for 3 cycles → pc_atual and profundidade hold. Assert reset_n=0 asynchronously mid-PARADO → all outputs at reset values immediately, without waiting for a clock edge.
